hazard_fwd_unit: RTL and testbench
==================================

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
REQ-004 id_rs1_used, id_rs2_used  input  1 each  the ID instruction actually reads that source.
REQ-005 id_rd  input  5  destination of the ID instruction.
REQ-006 id_reg_write, id_mem_read  input  1 each  ID instruction writes the register file / is a load.
REQ-007 ex_br_taken  input  1  branch/jump resolved taken in EX this cycle.
REQ-008 fwd_a_sel, fwd_b_sel  output  2 each  select codes for the EX-stage 3:1 operand muxes (rs1, rs2).
REQ-009 stall_pc, stall_ifid  output  1 each  hold PC and the IF/ID register.
REQ-010 flush_ifid, flush_idex  output  1 each  clear the IF/ID register / load a bubble into ID/EX.

Function
REQ-011 Select encoding SHALL be: 00 register-file value, 01 EX/MEM ALU result, 10 MEM/WB write-back value; 11 SHALL never be driven.
REQ-012 The unit SHALL hold three shadow records (EX, MEM, WB), each {rs1, rs2, rs1_used, rs2_used, rd, reg_write, mem_read}, advancing ID->EX->MEM->WB every cycle.
REQ-013 fwd_x_sel SHALL be combinational from the shadows: 01 if the MEM record has reg_write, rd!=0 and rd==EX.rsx with EX.rsx_used; else 10 under the same test against the WB record; else 00.
REQ-014 On a simultaneous MEM and WB match, MEM SHALL win (youngest value).
REQ-015 rd==x0 SHALL never cause forwarding or a stall.
REQ-016 Load-use: if the EX record has mem_read, rd!=0 and rd matches a used ID source, then stall_pc=stall_ifid=flush_idex=1 for exactly one cycle; the EX shadow SHALL load a bubble (all enables 0).
REQ-017 After a one-cycle load-use stall, the load reaches MEM->WB and forwarding SHALL select 10; no second stall.
REQ-018 ex_br_taken SHALL assert flush_ifid and flush_idex in the same cycle, and the EX shadow SHALL load a bubble on the next edge.
REQ-019 If ex_br_taken and a load-use condition coincide, the flush SHALL win: stall_pc=stall_ifid=0.
REQ-020 A bubble record SHALL never match for forwarding or stalling.
REQ-021 Stall/flush outputs are combinational; forward selects have zero-cycle latency relative to the shadow state.

Reset
REQ-022 On rst=1 at a clock edge, all three shadow records SHALL clear to bubbles.
REQ-023 While rst is high and after release, fwd_a_sel=fwd_b_sel=00 and stall_pc=stall_ifid=flush_ifid=flush_idex=0 until a real hazard enters.
REQ-024 rst asserted mid-stall SHALL abort the stall; no stall state survives reset.

Structure
REQ-025 Select-code constants (FWD_RF, FWD_MEM, FWD_WB) and the shadow-record field widths SHALL live in a shared package/header, used by this unit and the datapath.
REQ-026 One sub-module, fwd_cmp, SHALL compute one operand's select from (rs, used, MEM rd/we, WB rd/we); instantiated twice.
REQ-027 The operand muxes themselves stay in the datapath; this unit only drives selects.

Verification
REQ-028 add x5,x1,x2 then sub x6,x5,x3 -> in sub's EX cycle fwd_a_sel=01, fwd_b_sel=00, no stall.
REQ-029 add x5,.. ; nop ; or x7,x5,x5 -> or's EX cycle fwd_a_sel=fwd_b_sel=10.
REQ-030 lw x4,0(x1) then add x8,x4,x2 -> one cycle of stall_pc=stall_ifid=flush_idex=1, then add's EX cycle fwd_a_sel=10.
REQ-031 addi x0,x0,1 then add x9,x0,x0 -> selects 00, no stall.
REQ-032 lw x4 in EX, dependent add in ID, ex_br_taken=1 same cycle -> flush_ifid=flush_idex=1, stall_pc=0.
REQ-033 rst pulsed during a load-use stall -> next cycle all outputs 0, selects 00.

Source files
------------

// File: rtl/hazard_fwd_unit_pkg.sv
// Shared definitions for the hazard/forwarding unit and the datapath operand muxes.
// Holds the select codes, the shadow-record layout and the match helper used by both.
package hazard_fwd_unit_pkg;

    localparam int REG_W = 5;
    localparam int SEL_W = 2;

    localparam logic [SEL_W-1:0] FWD_RF  = 2'b00;
    localparam logic [SEL_W-1:0] FWD_MEM = 2'b01;
    localparam logic [SEL_W-1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             rs1_used;
        logic             rs2_used;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             mem_read;
    } shadow_rec_t;

    // All enables low: a bubble can never match anything.
    localparam shadow_rec_t BUBBLE = '0;

    // True when a producer writing rd feeds a consumer that really reads rs; x0 never counts.
    function automatic logic reg_hit(input logic we, input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] rs, input logic used);
        return we && used && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_fwd_unit_fwd_cmp.sv
// Operand-select comparator: picks the youngest in-flight producer of one EX source.
// The MEM stage is checked first so it wins over WB on a double match.
module fwd_cmp
    import hazard_fwd_unit_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic             used,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_we,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_we,
    output logic [SEL_W-1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (reg_hit(mem_we, mem_rd, rs, used)) begin
            sel = FWD_MEM;
        end else if (reg_hit(wb_we, wb_rd, rs, used)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding control: tracks EX/MEM/WB shadow records of the pipeline
// and drives operand-mux selects plus stall/flush controls for a 5-stage in-order core.
module hazard_fwd_unit
    import hazard_fwd_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             ex_br_taken,
    output logic [SEL_W-1:0] fwd_a_sel,
    output logic [SEL_W-1:0] fwd_b_sel,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             flush_ifid,
    output logic             flush_idex
);

    shadow_rec_t ex_reg, mem_reg, wb_reg;
    shadow_rec_t id_rec;
    shadow_rec_t ex_next;

    logic             load_use;
    logic             bubble_ex;
    logic [REG_W-1:0] ex_rs   [2];
    logic             ex_used [2];
    logic [SEL_W-1:0] sel     [2];

    assign id_rec = '{rs1: id_rs1, rs2: id_rs2, rs1_used: id_rs1_used, rs2_used: id_rs2_used,
                      rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};

    // A load in EX cannot forward to the instruction in ID before its data exists.
    assign load_use = reg_hit(ex_reg.mem_read, ex_reg.rd, id_rs1, id_rs1_used) ||
                      reg_hit(ex_reg.mem_read, ex_reg.rd, id_rs2, id_rs2_used);

    assign bubble_ex = load_use || ex_br_taken;
    assign ex_next   = bubble_ex ? BUBBLE : id_rec;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_reg  <= BUBBLE;
            mem_reg <= BUBBLE;
            wb_reg  <= BUBBLE;
        end else begin
            ex_reg  <= ex_next;
            mem_reg <= ex_reg;
            wb_reg  <= mem_reg;
        end
    end

    assign ex_rs[0]   = ex_reg.rs1;
    assign ex_rs[1]   = ex_reg.rs2;
    assign ex_used[0] = ex_reg.rs1_used;
    assign ex_used[1] = ex_reg.rs2_used;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
            fwd_cmp u_fwd_cmp (
                .rs     (ex_rs[gi]),
                .used   (ex_used[gi]),
                .mem_rd (mem_reg.rd),
                .mem_we (mem_reg.reg_write),
                .wb_rd  (wb_reg.rd),
                .wb_we  (wb_reg.reg_write),
                .sel    (sel[gi])
            );
        end
    endgenerate

    // Reset masks everything so no stale shadow state leaks out while rst is held.
    // A taken branch overrides a load-use stall: the dependent instruction is squashed anyway.
    assign fwd_a_sel  = rst ? FWD_RF : sel[0];
    assign fwd_b_sel  = rst ? FWD_RF : sel[1];
    assign stall_pc   = !rst && load_use && !ex_br_taken;
    assign stall_ifid = !rst && load_use && !ex_br_taken;
    assign flush_ifid = !rst && ex_br_taken;
    assign flush_idex = !rst && bubble_ex;

    // Source fields of the later stages and load flags past EX are carried only for debug visibility.
    logic unused_fields;
    assign unused_fields = ^{mem_reg.rs1, mem_reg.rs2, mem_reg.rs1_used, mem_reg.rs2_used,
                             mem_reg.mem_read, wb_reg.rs1, wb_reg.rs2, wb_reg.rs1_used,
                             wb_reg.rs2_used, wb_reg.mem_read};

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit: stimulus drives the ID stage each cycle and queues the
// hand-derived outputs for that cycle; a monitor pops and compares at the falling edge.
module tb_hazard_fwd_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic       id_reg_write = 1'b0, id_mem_read = 1'b0, ex_br_taken = 1'b0;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall_pc, stall_ifid, flush_ifid, flush_idex;

    hazard_fwd_unit dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .ex_br_taken  (ex_br_taken),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall_pc     (stall_pc),
        .stall_ifid   (stall_ifid),
        .flush_ifid   (flush_ifid),
        .flush_idex   (flush_idex)
    );

    always #5 clk = ~clk;

    // Expected vector layout: {fwd_a[1:0], fwd_b[1:0], stall_pc, stall_ifid, flush_ifid, flush_idex}
    localparam logic [7:0] E0      = 8'b00_00_0000;
    localparam logic [7:0] E_LU    = 8'b00_00_1101;
    localparam logic [7:0] E_BR    = 8'b00_00_0011;
    localparam logic [7:0] E_A01   = 8'b01_00_0000;
    localparam logic [7:0] E_AB01  = 8'b01_01_0000;
    localparam logic [7:0] E_AB10  = 8'b10_10_0000;
    localparam logic [7:0] E_A10   = 8'b10_00_0000;

    typedef struct {
        string      name;
        logic [7:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic step(input string name, input logic r, input logic br,
                        input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic we, input logic mr, input logic [7:0] ev);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; ex_br_taken = br;
        id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_reg_write = we; id_mem_read = mr;
        e.name = name;
        e.v    = ev;
        exp_q.push_back(e);
    endtask

    task automatic nop(input string name, input logic [7:0] ev);
        step(name, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, ev);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [7:0] got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {fwd_a_sel, fwd_b_sel, stall_pc, stall_ifid, flush_ifid, flush_idex};
                checks++;
                if (got !== e.v) begin
                    errors++;
                    $display("FAIL %s: got a=%b b=%b st=%b%b fl=%b%b, expected a=%b b=%b st=%b%b fl=%b%b",
                             e.name, got[7:6], got[5:4], got[3], got[2], got[1], got[0],
                             e.v[7:6], e.v[5:4], e.v[3], e.v[2], e.v[1], e.v[0]);
                end else begin
                    $display("ok   %s: a=%b b=%b st=%b%b fl=%b%b", e.name,
                             got[7:6], got[5:4], got[3], got[2], got[1], got[0]);
                end
            end
        end
    end

    initial begin : stimulus
        int wait_cycles;
        // Reset: outputs stay quiet even with a branch and a load in ID while rst is high.
        step("rst_idle",     1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, E0);
        step("rst_br_held",  1, 1, 5'd1, 1, 5'd0, 0, 5'd4, 1, 1, E0);
        step("rst_release",  0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, E0);
        nop("post_rst", E0);

        // add x5,x1,x2 ; sub x6,x5,x3 -> MEM forward on rs1 only
        step("add_x5",       0, 0, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, E0);
        step("sub_x6_id",    0, 0, 5'd5, 1, 5'd3, 1, 5'd6, 1, 0, E0);
        nop("sub_ex_fwd01", E_A01);
        nop("drain1a", E0);
        nop("drain1b", E0);

        // add x5 ; nop ; or x7,x5,x5 -> WB forward on both
        step("add_x5_b",     0, 0, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, E0);
        nop("gap", E0);
        step("or_x7_id",     0, 0, 5'd5, 1, 5'd5, 1, 5'd7, 1, 0, E0);
        nop("or_ex_fwd10", E_AB10);
        nop("drain2a", E0);
        nop("drain2b", E0);

        // Two writers of x5 back to back: MEM (younger) must beat WB
        step("add_x5_old",   0, 0, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, E0);
        step("add_x5_new",   0, 0, 5'd3, 1, 5'd4, 1, 5'd5, 1, 0, E0);
        step("sub_x5x5_id",  0, 0, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, E0);
        nop("sub_ex_mem_wins", E_AB01);
        nop("drain3a", E0);
        nop("drain3b", E0);

        // lw x4,0(x1) ; add x8,x4,x2 -> single stall, then WB forward
        step("lw_x4",        0, 0, 5'd1, 1, 5'd0, 0, 5'd4, 1, 1, E0);
        step("add_x8_stall", 0, 0, 5'd4, 1, 5'd2, 1, 5'd8, 1, 0, E_LU);
        step("add_x8_held",  0, 0, 5'd4, 1, 5'd2, 1, 5'd8, 1, 0, E0);
        nop("add_ex_fwd10", E_A10);
        nop("drain4a", E0);
        nop("drain4b", E0);

        // x0 never forwards or stalls
        step("addi_x0",      0, 0, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0, E0);
        step("add_x9_x0",    0, 0, 5'd0, 1, 5'd0, 1, 5'd9, 1, 0, E0);
        nop("add_ex_x0_nofwd", E0);
        step("lw_x0",        0, 0, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1, E0);
        step("use_x0_nostall", 0, 0, 5'd0, 1, 5'd0, 1, 5'd9, 1, 0, E0);
        nop("drain5a", E0);
        nop("drain5b", E0);

        // Branch taken coincident with load-use: flush wins, no stall
        step("lw_x4_b",      0, 0, 5'd1, 1, 5'd0, 0, 5'd4, 1, 1, E0);
        step("br_vs_lu",     0, 1, 5'd4, 1, 5'd2, 1, 5'd8, 1, 0, E_BR);
        nop("after_flush", E0);
        nop("drain6a", E0);
        nop("drain6b", E0);

        // Reset in the middle of a load-use stall
        step("lw_x4_c",      0, 0, 5'd1, 1, 5'd0, 0, 5'd4, 1, 1, E0);
        step("stall_c",      0, 0, 5'd4, 1, 5'd2, 1, 5'd8, 1, 0, E_LU);
        step("rst_mid_stall", 1, 0, 5'd4, 1, 5'd2, 1, 5'd8, 1, 0, E0);
        step("post_rst_c",   0, 0, 5'd4, 1, 5'd2, 1, 5'd8, 1, 0, E0);
        nop("post_rst_c2", E0);

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
